// File: rtl/imm_enc_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_enc_if : request/encoded-beat bundle for the immediate encoder        |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
interface imm_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_op;
  logic [4:0]  out_iimm_shamt;
  logic [11:0] out_iimm;
  logic [11:0] out_simm;
  logic [11:0] out_bimm;
  logic [19:0] out_uimm;
  logic [19:0] out_jimm;
  logic        out_err;
  logic        out_last;

  modport master (
    output in_valid, in_op, in_imm, out_ready,
    input  in_ready, out_valid, out_op, out_iimm_shamt, out_iimm, out_simm,
           out_bimm, out_uimm, out_jimm, out_err, out_last
  );

  modport slave (
    input  in_valid, in_op, in_imm, out_ready,
    output in_ready, out_valid, out_op, out_iimm_shamt, out_iimm, out_simm,
           out_bimm, out_uimm, out_jimm, out_err, out_last
  );
endinterface
`default_nettype wire

// File: rtl/imm_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_enc : encodes a 32-bit immediate into RISC-V style instruction fields |
// |           with range checking; IMM_ENC_SPLIT_EN splits wide ITYPE values  |
// |           into a UTYPE + ITYPE beat pair.                                 |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module imm_enc (
  input  wire logic  clk,
  input  wire logic  rst,
  imm_enc_if.slave   bus
);
  localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    EMIT_LO = 1'b1
  } state_t;

  state_t      state_q;
  logic        valid_q;
  logic [5:0]  op_q;
  logic [4:0]  shamt_q;
  logic [11:0] iimm_q;
  logic [11:0] simm_q;
  logic [11:0] bimm_q;
  logic [19:0] uimm_q;
  logic [19:0] jimm_q;
  logic        err_q;
  logic        last_q;
`ifdef IMM_ENC_SPLIT_EN
  logic [11:0] pend_iimm_q;
`endif

  logic        in_ready;
  logic        accept;
  logic        i_fits;
  logic [5:0]  enc_op;
  logic [4:0]  enc_shamt;
  logic [11:0] enc_iimm;
  logic [11:0] enc_simm;
  logic [11:0] enc_bimm;
  logic [19:0] enc_uimm;
  logic [19:0] enc_jimm;
  logic        enc_err;
  logic        enc_last;
  logic        enc_split;

  assign in_ready = (state_q == IDLE) && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  // 12-bit signed range: bits [31:11] must all be copies of the sign bit.
  assign i_fits   = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);

  always_comb begin
    enc_op    = bus.in_op;
    enc_shamt = '0;
    enc_iimm  = '0;
    enc_simm  = '0;
    enc_bimm  = '0;
    enc_uimm  = '0;
    enc_jimm  = '0;
    enc_err   = 1'b0;
    enc_last  = 1'b1;
    enc_split = 1'b0;
    case (bus.in_op)
      EXT_CTRL_ITYPE_SHAMT: begin
        enc_shamt = bus.in_imm[4:0];
        enc_err   = |bus.in_imm[31:5];
      end
      EXT_CTRL_ITYPE: begin
        enc_iimm = bus.in_imm[11:0];
        enc_err  = !i_fits;
`ifdef IMM_ENC_SPLIT_EN
        if (!i_fits) begin
          // Upper part is rounded so the sign-extended low 12 bits add back exactly.
          enc_op    = EXT_CTRL_UTYPE;
          enc_iimm  = '0;
          enc_uimm  = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};
          enc_err   = 1'b0;
          enc_last  = 1'b0;
          enc_split = 1'b1;
        end
`endif
      end
      EXT_CTRL_STYPE: begin
        enc_simm = bus.in_imm[11:0];
        enc_err  = !i_fits;
      end
      EXT_CTRL_BTYPE: begin
        enc_bimm = bus.in_imm[12:1];
        enc_err  = bus.in_imm[0] || (bus.in_imm[31:12] != {20{bus.in_imm[12]}});
      end
      EXT_CTRL_UTYPE: begin
        enc_uimm = bus.in_imm[31:12];
        enc_err  = |bus.in_imm[11:0];
      end
      EXT_CTRL_JTYPE: begin
        enc_jimm = bus.in_imm[20:1];
        enc_err  = bus.in_imm[0] || (bus.in_imm[31:20] != {12{bus.in_imm[20]}});
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      op_q    <= '0;
      shamt_q <= '0;
      iimm_q  <= '0;
      simm_q  <= '0;
      bimm_q  <= '0;
      uimm_q  <= '0;
      jimm_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
`ifdef IMM_ENC_SPLIT_EN
      pend_iimm_q <= '0;
`endif
    end else if (accept) begin
      valid_q <= 1'b1;
      op_q    <= enc_op;
      shamt_q <= enc_shamt;
      iimm_q  <= enc_iimm;
      simm_q  <= enc_simm;
      bimm_q  <= enc_bimm;
      uimm_q  <= enc_uimm;
      jimm_q  <= enc_jimm;
      err_q   <= enc_err;
      last_q  <= enc_last;
      state_q <= enc_split ? EMIT_LO : IDLE;
`ifdef IMM_ENC_SPLIT_EN
      pend_iimm_q <= bus.in_imm[11:0];
`endif
`ifdef IMM_ENC_SPLIT_EN
    end else if ((state_q == EMIT_LO) && bus.out_ready) begin
      valid_q <= 1'b1;
      op_q    <= EXT_CTRL_ITYPE;
      shamt_q <= '0;
      iimm_q  <= pend_iimm_q;
      simm_q  <= '0;
      bimm_q  <= '0;
      uimm_q  <= '0;
      jimm_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      state_q <= IDLE;
`endif
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = valid_q;
  assign bus.out_op         = op_q;
  assign bus.out_iimm_shamt = shamt_q;
  assign bus.out_iimm       = iimm_q;
  assign bus.out_simm       = simm_q;
  assign bus.out_bimm       = bimm_q;
  assign bus.out_uimm       = uimm_q;
  assign bus.out_jimm       = jimm_q;
  assign bus.out_err        = err_q;
  assign bus.out_last       = last_q;
endmodule
`default_nettype wire

// File: tb/tb_imm_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imm_enc : randomized + directed self-checking bench for imm_enc        |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_imm_enc;
  localparam logic [5:0] SH = 6'b100000;
  localparam logic [5:0] IT = 6'b010000;
  localparam logic [5:0] ST = 6'b001000;
  localparam logic [5:0] BT = 6'b000100;
  localparam logic [5:0] UT = 6'b000010;
  localparam logic [5:0] JT = 6'b000001;

  logic clk;
  logic rst;
  imm_enc_if bus ();

  imm_enc dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_deliv = 0;
  logic [88:0] exp_q[$];

  task automatic chk(input string tag, input logic [88:0] got, input logic [88:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [88:0] beat(input logic [5:0] op, input logic [4:0] sh,
      input logic [11:0] ii, input logic [11:0] si, input logic [11:0] bi,
      input logic [19:0] ui, input logic [19:0] ji, input logic err, input logic last);
    return {op, sh, ii, si, bi, ui, ji, err, last};
  endfunction

  function automatic logic [88:0] observed();
    return {bus.out_op, bus.out_iimm_shamt, bus.out_iimm, bus.out_simm, bus.out_bimm,
            bus.out_uimm, bus.out_jimm, bus.out_err, bus.out_last};
  endfunction

  // Reference: range rules expressed as signed-integer bounds and alignment.
  task automatic model_push(input logic [5:0] op, input logic [31:0] imm);
    longint sv;
    bit      bad;
    logic [31:0] t;
    sv = longint'($signed(imm));
    case (op)
      SH: exp_q.push_back(beat(op, 5'(imm % 32), 0, 0, 0, 0, 0, imm > 31, 1));
      IT: begin
        bad = (sv < -2048) || (sv > 2047);
`ifdef IMM_ENC_SPLIT_EN
        if (bad) begin
          t = (imm + 32'h800) >> 12;
          exp_q.push_back(beat(UT, 0, 0, 0, 0, t[19:0], 0, 0, 0));
          exp_q.push_back(beat(IT, 0, imm[11:0], 0, 0, 0, 0, 0, 1));
        end else
`endif
          exp_q.push_back(beat(op, 0, 12'(imm & 32'hFFF), 0, 0, 0, 0, bad, 1));
      end
      ST: exp_q.push_back(beat(op, 0, 0, 12'(imm & 32'hFFF), 0, 0, 0,
                               (sv < -2048) || (sv > 2047), 1));
      BT: begin
        t = imm >> 1;
        exp_q.push_back(beat(op, 0, 0, 0, t[11:0], 0, 0,
                             (imm % 2 != 0) || (sv < -4096) || (sv > 4094), 1));
      end
      UT: begin
        t = imm / 4096;
        exp_q.push_back(beat(op, 0, 0, 0, 0, t[19:0], 0, imm % 4096 != 0, 1));
      end
      JT: begin
        t = imm >> 1;
        exp_q.push_back(beat(op, 0, 0, 0, 0, 0, t[19:0],
                             (imm % 2 != 0) || (sv < -1048576) || (sv > 1048574), 1));
      end
      default: exp_q.push_back(beat(op, 0, 0, 0, 0, 0, 0, 1, 1));
    endcase
  endtask

  logic        hold = 1'b0;
  logic [88:0] held;

  always @(negedge clk) begin
    logic [88:0] got;
    got = observed();
    if (rst) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_beat", got, held);
        chk("hold_valid", 89'(bus.out_valid), 89'(1));
      end
      chk("in_ready", 89'(bus.in_ready),
          89'((exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_ready)));
      chk("out_valid", 89'(bus.out_valid), 89'(exp_q.size() != 0));
      if (bus.out_valid && exp_q.size() != 0) chk("beat", got, exp_q[0]);
      hold = bus.out_valid && !bus.out_ready;
      held = got;
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_deliv++;
      end
      if (bus.in_valid && bus.in_ready) model_push(bus.in_op, bus.in_imm);
    end
  end

  task automatic send(input logic [5:0] op, input logic [31:0] imm);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_imm   = imm;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 89'(0), 89'(1));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic [5:0] op, input logic [31:0] imm,
                          input logic [88:0] exp);
    bus.out_ready = 1'b1;
    send(op, imm);
    @(negedge clk);
    chk(tag, {observed(), bus.out_valid}, {exp, 1'b1});
  endtask

  function automatic logic [31:0] pick_imm();
    case ($urandom % 6)
      0:       return $urandom;
      1:       return $urandom % 64;
      2:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      3:       return 32'($urandom_range(0, 4095)) + 32'hFFFFF000 - 32'd2048;
      4:       return $urandom & 32'hFFFFF000;
      default: return 32'($urandom_range(0, 7)) + 32'h000FFFFC + (($urandom % 2) * 32'hFFE00000);
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [6];
    ops = '{SH, IT, ST, BT, UT, JT};
    if ($urandom % 10 == 0) return 6'($urandom);
    return ops[$urandom % 6];
  endfunction

  initial begin
    int d0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_fields", observed(), '0);
    chk("rst_valid", 89'(bus.out_valid), 89'(0));
    chk("rst_in_ready", 89'(bus.in_ready), 89'(1));

    send_chk("itype_neg", IT, 32'hFFFFF800, beat(IT, 0, 12'h800, 0, 0, 0, 0, 0, 1));
    send_chk("btype_max", BT, 32'h00000FFE, beat(BT, 0, 0, 0, 12'h7FF, 0, 0, 0, 1));
    send_chk("btype_odd", BT, 32'h00000003, beat(BT, 0, 0, 0, 12'h001, 0, 0, 1, 1));
    send_chk("jtype_min", JT, 32'hFFF00000, beat(JT, 0, 0, 0, 0, 0, 20'h80000, 0, 1));
    send_chk("utype_low", UT, 32'h12345001, beat(UT, 0, 0, 0, 0, 20'h12345, 0, 1, 1));
    send_chk("illegal_op", 6'b000011, 32'hDEADBEEF, beat(6'b000011, 0, 0, 0, 0, 0, 0, 1, 1));
`ifdef IMM_ENC_SPLIT_EN
    send_chk("split_b1", IT, 32'h12345FFF, beat(UT, 0, 0, 0, 0, 20'h12346, 0, 0, 0));
    @(negedge clk);
    chk("split_b2", {observed(), bus.out_valid}, {beat(IT, 0, 12'hFFF, 0, 0, 0, 0, 0, 1), 1'b1});
`else
    send_chk("wide_itype", IT, 32'h12345FFF, beat(IT, 0, 12'hFFF, 0, 0, 0, 0, 1, 1));
`endif
    repeat (3) @(posedge clk);

    // Backpressure: SHAMT beat held for three cycles, delivered exactly once.
    #1 bus.out_ready = 1'b0;
    send(SH, 32'd31);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 89'(bus.in_ready), 89'(0));
      chk("bp_shamt", 89'(bus.out_iimm_shamt), 89'(31));
    end
    d0 = n_deliv;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_once", 89'(n_deliv - d0), 89'(1));

    // Reset while a (possibly split) wide ITYPE result is held.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(IT, 32'h12345FFF);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_drop", 89'(bus.out_valid), 89'(0));
    end

    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      rst           = ($urandom % 150) == 0;
      bus.in_valid  = ($urandom % 3) != 0;
      bus.out_ready = ($urandom % 4) != 0;
      bus.in_op     = pick_op();
      bus.in_imm    = pick_imm();
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("drain", 89'(exp_q.size()), 89'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/imm_enc.md
IMM_ENC -- requirements
Module: imm_enc

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port in_valid  input  1  request present.
REQ-004 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at clk edge.
REQ-005 SHALL have port in_op  input  6  immediate type, same one-hot encoding as the EXTOp bus (see REQ-010).
REQ-006 SHALL have port in_imm  input  32  full 32-bit immediate value to encode.
REQ-007 SHALL have port out_valid  input/output: output  1  encoded beat present.
REQ-008 SHALL have port out_ready  input  1  consumer accepts beat when out_valid && out_ready.
REQ-009 SHALL have output ports out_op[5:0], out_iimm_shamt[4:0], out_iimm[11:0], out_simm[11:0], out_bimm[11:0], out_uimm[19:0], out_jimm[19:0], out_err[0], out_last[0]: instruction immediate fields, type, error flag, last beat of request.

Function
REQ-010 SHALL decode in_op: `EXT_CTRL_ITYPE_SHAMT 6'b100000, `EXT_CTRL_ITYPE 6'b010000, `EXT_CTRL_STYPE 6'b001000, `EXT_CTRL_BTYPE 6'b000100, `EXT_CTRL_UTYPE 6'b000010, `EXT_CTRL_JTYPE 6'b000001; any other value is illegal.
REQ-011 SHALL produce fields that re-extend to in_imm: shamt=imm[4:0]; iimm=imm[11:0]; simm=imm[11:0]; bimm=imm[12:1]; uimm=imm[31:12]; jimm=imm[20:1]; only the field selected by out_op carries data, all other field outputs 0.
REQ-012 SHALL set out_err=1 when: SHAMT and imm[31:5]!=0; ITYPE/STYPE and imm[31:11] not all equal; BTYPE and (imm[0]=1 or imm[31:12] not all equal imm[12]); JTYPE and (imm[0]=1 or imm[31:20] not all equal imm[20]); UTYPE and imm[11:0]!=0; illegal op (out_op=in_op, all fields 0).
REQ-013 SHALL present truncated field bits per REQ-011 even when out_err=1 (legal op).
REQ-014 SHALL register outputs: accepted request appears on out_* the cycle after acceptance (latency 1).
REQ-015 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-016 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready), combinationally; back-to-back requests at one per cycle when out_ready=1.
REQ-017 SHALL implement states IDLE and EMIT_LO; IDLE->EMIT_LO only on accepted split request (REQ-022); EMIT_LO->IDLE when second beat is loaded into output register.
REQ-018 SHALL assert out_last=1 on every single-beat result and on the second beat of a split.

Reset
REQ-019 SHALL, when rst=1 at a clk edge, set state=IDLE, out_valid=0, out_op=0, all field outputs 0, out_err=0, out_last=0; in_ready=1 the cycle after rst deasserts.
REQ-020 SHALL drop any pending second beat and the held output beat when rst asserts mid-operation; no beat emitted after reset until a new acceptance.
REQ-021 SHALL ignore in_valid during a rst=1 cycle.

Configuration
REQ-022 SHALL, with macro IMM_ENC_SPLIT_EN defined, encode an out-of-range ITYPE request (err condition of REQ-012) as two beats: beat 1 out_op=UTYPE, uimm=(imm+32'h800)[31:12], out_err=0, out_last=0; beat 2 out_op=ITYPE, iimm=imm[11:0], out_err=0, out_last=1; in_ready=0 until beat 2 is loaded.
REQ-023 SHALL, without IMM_ENC_SPLIT_EN, emit an out-of-range ITYPE request as one beat with out_err=1, out_last=1; state EMIT_LO unreachable.

Verification
REQ-024 SHALL cover: ITYPE imm=32'hFFFFF800 -> one beat, iimm=12'h800, err=0, last=1, one cycle after acceptance.
REQ-025 SHALL cover: BTYPE imm=32'h00000FFE -> bimm=12'h7FF, err=0; BTYPE imm=32'h00000003 -> err=1, bimm=12'h001.
REQ-026 SHALL cover: JTYPE imm=32'hFFF00000 -> jimm=20'h80000, err=0; UTYPE imm=32'h12345001 -> err=1, uimm=20'h12345.
REQ-027 SHALL cover: out_ready=0 for 3 cycles with SHAMT imm=5'd31 held -> outputs stable, in_ready=0, shamt=5'd31 delivered once on out_ready=1.
REQ-028 SHALL cover (SPLIT_EN): ITYPE imm=32'h12345FFF -> beat1 UTYPE uimm=20'h12346 last=0, beat2 ITYPE iimm=12'hFFF last=1; rst between beats -> beat2 never appears; without macro -> single beat err=1.
REQ-029 SHALL cover: in_op=6'b000011 -> err=1, all fields 0, last=1.
